// File: rtl/reorder_buffer.sv
// In-order retirement buffer after register rename: entries are allocated at the tail,
// marked complete by tag, and retired from the head one per cycle, releasing the old mapping.

module rob_entry #(
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_wr,
  input  logic              i_set_done,
  input  logic              i_retire,
  input  logic [ARCH_W-1:0] i_arch,
  input  logic [PHYS_W-1:0] i_phys,
  input  logic [PHYS_W-1:0] i_old,
  output logic              o_done,
  output logic [ARCH_W-1:0] o_arch,
  output logic [PHYS_W-1:0] o_phys,
  output logic [PHYS_W-1:0] o_old
);
  logic r_vld;

  // A write only targets a free slot, so it safely overrides a stray completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld  <= 1'b0;
      o_done <= 1'b0;
      o_arch <= '0;
      o_phys <= '0;
      o_old  <= '0;
    end else if (i_clr) begin
      r_vld  <= 1'b0;
      o_done <= 1'b0;
    end else if (i_wr) begin
      r_vld  <= 1'b1;
      o_done <= 1'b0;
      o_arch <= i_arch;
      o_phys <= i_phys;
      o_old  <= i_old;
    end else if (i_retire) begin
      r_vld  <= 1'b0;
      o_done <= 1'b0;
    end else if (i_set_done && r_vld) begin
      o_done <= 1'b1;
    end
  end
endmodule

module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [ARCH_W-1:0] alloc_arch_dest,
  input  logic [PHYS_W-1:0] alloc_phys_dest,
  input  logic [PHYS_W-1:0] alloc_old_phys,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  output logic              commit_valid,
  output logic [ARCH_W-1:0] commit_arch_dest,
  output logic [PHYS_W-1:0] commit_phys_dest,
  output logic              free_valid,
  output logic [PHYS_W-1:0] commit_old_phys,
  output logic [TAG_W:0]    rob_count
);
  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  logic [TAG_W:0] r_head, r_tail;
  logic [TAG_W-1:0] w_hidx, w_tidx;
  logic w_empty, w_full, w_fire;
  logic [DEPTH-1:0] w_done;
  logic [DEPTH-1:0][ARCH_W-1:0] w_arch;
  logic [DEPTH-1:0][PHYS_W-1:0] w_phys, w_old;

  assign w_hidx  = r_head[TAG_W-1:0];
  assign w_tidx  = r_tail[TAG_W-1:0];
  assign w_empty = (r_head == r_tail);
  assign w_full  = (w_hidx == w_tidx) && (r_head[TAG_W] != r_tail[TAG_W]);

  assign alloc_ready = !w_full;
  assign alloc_tag   = w_tidx;
  assign w_fire      = alloc_valid && alloc_ready && !flush;
  assign rob_count   = r_tail - r_head;

  assign commit_valid     = !flush && !w_empty && w_done[w_hidx];
  assign commit_arch_dest = commit_valid ? w_arch[w_hidx] : '0;
  assign commit_phys_dest = commit_valid ? w_phys[w_hidx] : '0;
  assign commit_old_phys  = commit_valid ? w_old[w_hidx]  : '0;
  // x0 never held a real mapping, so its old physical register is not returned.
  assign free_valid       = commit_valid && (w_arch[w_hidx] != '0);

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rob_entry #(.ARCH_W(ARCH_W), .PHYS_W(PHYS_W)) u_ent (
      .clk        (clk),
      .reset      (reset),
      .i_clr      (flush),
      .i_wr       (w_fire && (w_tidx == TAG_W'(g))),
      .i_set_done (cmpl_valid && (cmpl_tag == TAG_W'(g))),
      .i_retire   (commit_valid && (w_hidx == TAG_W'(g))),
      .i_arch     (alloc_arch_dest),
      .i_phys     (alloc_phys_dest),
      .i_old      (alloc_old_phys),
      .o_done     (w_done[g]),
      .o_arch     (w_arch[g]),
      .o_phys     (w_phys[g]),
      .o_old      (w_old[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_fire)       r_tail <= r_tail + PTR_ONE;
      if (commit_valid) r_head <= r_head + PTR_ONE;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized + directed bench: a queue-based program-order model predicts state each cycle,
// and a scoreboard of allocated entries is popped by a monitor on every commit.
module tb_reorder_buffer;
  logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic alloc_valid = 1'b0, alloc_ready;
  logic [4:0] alloc_arch_dest = '0;
  logic [5:0] alloc_phys_dest = '0, alloc_old_phys = '0;
  logic [3:0] alloc_tag;
  logic cmpl_valid = 1'b0;
  logic [3:0] cmpl_tag = '0;
  logic commit_valid, free_valid;
  logic [4:0] commit_arch_dest;
  logic [5:0] commit_phys_dest, commit_old_phys;
  logic [4:0] rob_count;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_arch_dest(alloc_arch_dest), .alloc_phys_dest(alloc_phys_dest),
    .alloc_old_phys(alloc_old_phys), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag),
    .commit_valid(commit_valid), .commit_arch_dest(commit_arch_dest),
    .commit_phys_dest(commit_phys_dest), .free_valid(free_valid),
    .commit_old_phys(commit_old_phys), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [5:0] p; logic [5:0] o; } ent_t;
  ent_t sb[$];       // allocated entries awaiting commit, program order
  int   mq[$];       // tags of live entries, program order
  bit   mdone[16];
  bit   mvld[16];
  int   mtail = 0;
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    for (int i = 0; i < 16; i++) begin mvld[i] = 0; mdone[i] = 0; end
    mtail = 0;
  endtask

  // One clock cycle with the currently driven inputs: check at negedge, advance model at posedge.
  task automatic tick();
    bit cv, dc, da;
    int t;
    ent_t e;
    @(negedge clk);
    cv = !flush && mq.size() > 0 && mdone[mq[0]];
    chk("commit_valid", {31'b0, commit_valid}, {31'b0, cv});
    chk("alloc_ready", {31'b0, alloc_ready}, (mq.size() < 16) ? 32'd1 : 32'd0);
    chk("alloc_tag", {28'b0, alloc_tag}, mtail);
    chk("rob_count", {27'b0, rob_count}, mq.size());
    @(posedge clk);
    if (flush) model_clear();
    else begin
      dc = cmpl_valid && mvld[cmpl_tag];
      da = alloc_valid && mq.size() < 16;
      if (dc) mdone[cmpl_tag] = 1;
      if (cv) begin t = mq.pop_front(); mvld[t] = 0; mdone[t] = 0; end
      if (da) begin
        mvld[mtail] = 1; mdone[mtail] = 0; mq.push_back(mtail);
        e.a = alloc_arch_dest; e.p = alloc_phys_dest; e.o = alloc_old_phys;
        sb.push_back(e);
        mtail = (mtail + 1) % 16;
      end
    end
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; cmpl_valid = 0;
  endtask

  task automatic reset_dut();
    idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
  endtask

  task automatic do_alloc(input logic [4:0] a, input logic [5:0] p, input logic [5:0] o);
    alloc_valid = 1; alloc_arch_dest = a; alloc_phys_dest = p; alloc_old_phys = o;
    tick();
    alloc_valid = 0;
  endtask

  task automatic do_cmpl(input int t);
    cmpl_valid = 1; cmpl_tag = 4'(t);
    tick();
    cmpl_valid = 0;
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Scoreboard monitor: every commit must match the oldest outstanding allocation.
  always @(negedge clk) begin
    ent_t e;
    if (!reset) begin
      if (commit_valid) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty: commit arch %0d with nothing outstanding", commit_arch_dest);
        end else begin
          e = sb.pop_front();
          chk("commit_arch", {27'b0, commit_arch_dest}, {27'b0, e.a});
          chk("commit_phys", {26'b0, commit_phys_dest}, {26'b0, e.p});
          chk("commit_old", {26'b0, commit_old_phys}, {26'b0, e.o});
          chk("free_valid", {31'b0, free_valid}, (e.a != 0) ? 32'd1 : 32'd0);
        end
      end else begin
        chk("idle_outputs", {14'b0, free_valid, commit_arch_dest, commit_phys_dest, commit_old_phys}, 32'd0);
      end
    end
  end

  initial begin
    int t;
    reset_dut();
    idle_n(1);

    // 1: async reset with live entries, checked before any clock edge
    do_alloc(5'd1, 6'd10, 6'd1);
    do_alloc(5'd2, 6'd11, 6'd2);
    do_alloc(5'd3, 6'd12, 6'd3);
    #1 reset = 1;
    #1;
    chk("rst_rob_count", {27'b0, rob_count}, 32'd0);
    chk("rst_commit_valid", {31'b0, commit_valid}, 32'd0);
    chk("rst_alloc_ready", {31'b0, alloc_ready}, 32'd1);
    chk("rst_alloc_tag", {28'b0, alloc_tag}, 32'd0);
    model_clear();
    @(posedge clk); #1 reset = 0;

    // 2: rename sequence, out-of-order completion, in-order retirement
    do_alloc(5'd5, 6'd32, 6'd5);
    do_alloc(5'd5, 6'd33, 6'd32);
    do_alloc(5'd6, 6'd34, 6'd6);
    do_cmpl(2); do_cmpl(1); do_cmpl(0);
    idle_n(4);

    // 3: fill, commit with alloc refused while full, then wrap
    reset_dut();
    for (int i = 0; i < 16; i++) do_alloc(5'(i + 1), 6'(i + 20), 6'(i + 40));
    chk("full_ready", {31'b0, alloc_ready}, 32'd0);
    chk("full_count", {27'b0, rob_count}, 32'd16);
    do_cmpl(0);
    alloc_valid = 1; alloc_arch_dest = 5'd9; alloc_phys_dest = 6'd50; alloc_old_phys = 6'd9;
    tick();
    tick();
    alloc_valid = 0;
    for (int i = 0; i < 16; i++) do_cmpl((i + 1) % 16);
    idle_n(20);

    // 4: x0 destination commits without freeing
    t = mtail;
    do_alloc(5'd0, 6'd40, 6'd0);
    do_cmpl(t);
    idle_n(3);

    // 5: completion of an empty slot is dropped
    reset_dut();
    do_cmpl(7);
    for (int i = 0; i < 8; i++) do_alloc(5'(i + 3), 6'(i + 1), 6'(i + 33));
    for (int i = 0; i < 7; i++) do_cmpl(i);
    idle_n(10);
    chk("stale_cmpl_count", {27'b0, rob_count}, 32'd1);
    chk("stale_cmpl_commit", {31'b0, commit_valid}, 32'd0);
    do_cmpl(7);
    idle_n(3);

    // 6: flush overrides alloc, completion and a ready commit
    reset_dut();
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 6'(i + 8), 6'(i + 16));
    do_cmpl(0);
    flush = 1; alloc_valid = 1; cmpl_valid = 1; cmpl_tag = 4'd1;
    tick();
    idle();
    tick();
    chk("flush_count", {27'b0, rob_count}, 32'd0);
    chk("flush_tag", {28'b0, alloc_tag}, 32'd0);

    // Random traffic
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      flush = ($urandom_range(199) == 0);
      alloc_valid = ($urandom_range(9) < 6);
      alloc_arch_dest = 5'($urandom_range(31));
      alloc_phys_dest = 6'($urandom_range(63));
      alloc_old_phys = 6'($urandom_range(63));
      cmpl_valid = ($urandom_range(9) < 5);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        cmpl_tag = 4'(mq[$urandom_range(mq.size() - 1)]);
      else
        cmpl_tag = 4'($urandom_range(15));
      tick();
    end
    idle();
    while (mq.size() > 0) begin
      t = mq[mq.size() - 1];
      for (int i = 0; i < mq.size(); i++) if (!mdone[mq[i]]) t = mq[i];
      do_cmpl(t);
      if (mdone[mq[mq.size() - 1]] && mq.size() > 0) idle_n(1);
    end
    idle_n(5);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
